axis_fork_router: RTL and testbench
===================================

Name: axis_fork_router

Overview:
- Parametrised AXI4-Stream 1-to-M_COUNT packet router; successor of the fixed 3-port fork arbiter.
- Two modes, decided per packet:
  - Broadcast: every beat is copied to every output selected by dest_mask.
  - Single: one output per packet, picked by round-robin arbitration among the dest_mask bits.
- Each output has its own registered slot, so a slow sink stalls the input but never corrupts other outputs.
- Sits between the PCIe/DMA ingress stream and the PAICORE chip-lane transmit queues.

Parameters:
- M_COUNT, 4, number of output ports (2..16).
- DATA_WIDTH, 64, tdata width in bits.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- fork_enable  input  1  1 = broadcast mode, 0 = single (round-robin) mode; sampled at packet start.
- dest_mask  input  M_COUNT  eligible/target outputs; sampled at packet start.
- s_axis_tready  output  1  input ready.
- s_axis_tdata  input  DATA_WIDTH  input data.
- s_axis_tlast  input  1  input end of packet.
- s_axis_tvalid  input  1  input valid.
- m_axis_tready  input  M_COUNT  per-output ready.
- m_axis_tdata  output  M_COUNT*DATA_WIDTH  output data; port i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- m_axis_tlast  output  M_COUNT  per-output tlast.
- m_axis_tvalid  output  M_COUNT  per-output valid.
- busy  output  1  high while a packet is in progress (state PASS or DROP).
- pkt_drop  output  1  one-cycle pulse when a packet starts with dest_mask==0.

Behaviour:
- Reset:
  - rst is synchronous; everything below applies on the clk edge where rst=1.
  - State goes to IDLE. route_mask=0. rr_ptr=M_COUNT-1.
  - All m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0. busy=0, pkt_drop=0.
  - s_axis_tready=0 while rst=1.
- Reset mid-packet: the in-flight packet is abandoned and output slots are cleared without being delivered. The next beat presented is treated as a packet start.
- Per-packet target (tgt), evaluated combinationally in IDLE from the current fork_enable and dest_mask:
  - fork_enable=1: tgt = dest_mask.
  - fork_enable=0: tgt = one-hot of the first set bit of dest_mask, scanning upward from (rr_ptr+1) mod M_COUNT and wrapping.
  - dest_mask==0: tgt=0, which means drop.
- In PASS state, tgt = route_mask. Changes to fork_enable and dest_mask mid-packet are ignored.
- Slot free condition: slot_free[i] = !m_axis_tvalid[i] || m_axis_tready[i].
- s_axis_tready:
  - 1 when not in reset and every i with tgt[i]=1 has slot_free[i].
  - Always 1 in DROP state, and in IDLE when dest_mask==0.
- Accepted beat, non-drop:
  - For each target i, the slot loads tdata/tlast and sets m_axis_tvalid[i]=1 on the next edge. Latency is 1 cycle.
  - Non-target slots drain independently: m_axis_tvalid[i] clears when m_axis_tready[i]=1 and no new load occurs.
- Throughput: 1 beat/cycle when all targets are ready. No bubble between packets.
- State machine (IDLE, PASS, DROP):
  - IDLE, accepted beat, tgt!=0, tlast=0 -> PASS; route_mask <= tgt.
  - IDLE, accepted beat, tgt!=0, tlast=1 -> stay IDLE (single-beat packet).
  - IDLE, accepted beat, tgt==0: pkt_drop pulses; tlast=0 -> DROP, tlast=1 -> stay IDLE.
  - PASS, accepted beat with tlast=1 -> IDLE.
  - DROP: beats are accepted and discarded; accepted beat with tlast=1 -> IDLE.
- Round-robin pointer:
  - In single mode, rr_ptr <= granted index on the packet's first accepted beat.
  - Broadcast packets and dropped packets leave rr_ptr unchanged.
- Simultaneous reload and drain on the same slot in one cycle: the slot holds the new beat and m_axis_tvalid stays 1.
- Back-pressure is the AND across targets: a beat is committed to all targets in the same cycle or to none. There is never partial delivery of a beat.
- Input without tvalid: nothing changes except slot drains.

Test Plan:
- Broadcast: M_COUNT=4, fork_enable=1, dest_mask=4'b1011, 3-beat packet 0x11/0x22/0x33 (last on 0x33), all ready. -> Ports 0, 1, 3 each show 0x11, 0x22, 0x33 one cycle after each input handshake, tlast on 0x33. Port 2 tvalid stays 0. s_axis_tready stays 1 throughout.
- Round-robin: fork_enable=0, dest_mask=4'b0110, four 1-beat packets 0xA0..0xA3. -> Delivered to ports 1, 2, 1, 2 in order; rr_ptr ends at 2.
- Stall: broadcast to 4'b0011, hold m_axis_tready[1]=0 for 5 cycles. -> s_axis_tready=0 after port 1's slot fills. Port 0 receives no further beat until port 1 drains. No beat is lost or duplicated.
- Drop: dest_mask=0, 2-beat packet. -> Both beats accepted with s_axis_tready=1. pkt_drop pulses once on the first beat. No output tvalid. The next packet to mask 4'b0001 arrives on port 0.
- Mask change mid-packet: start a single-mode packet granted to port 3, switch dest_mask to 4'b0001 on beat 2. -> All beats still go to port 3.
- Reset mid-packet: assert rst for 1 cycle in PASS with slots full. -> All m_axis_tvalid=0, busy=0 next cycle. The following beat is routed as a new packet with rr_ptr=M_COUNT-1, so the lowest set bit of dest_mask wins.

Source files
------------

// File: rtl/axis_fork_router.sv
// AXI4-Stream 1-to-M_COUNT packet router: per-packet broadcast to dest_mask or
// single-output round-robin, with one registered output slot per port.
module axis_fork_router #(
  parameter int M_COUNT    = 4,
  parameter int DATA_WIDTH = 64
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            fork_enable,
  input  logic [M_COUNT-1:0]              dest_mask,
  output logic                            s_axis_tready,
  input  logic [DATA_WIDTH-1:0]           s_axis_tdata,
  input  logic                            s_axis_tlast,
  input  logic                            s_axis_tvalid,
  input  logic [M_COUNT-1:0]              m_axis_tready,
  output logic [M_COUNT*DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [M_COUNT-1:0]              m_axis_tlast,
  output logic [M_COUNT-1:0]              m_axis_tvalid,
  output logic                            busy,
  output logic                            pkt_drop
);

  localparam int PTR_W = (M_COUNT > 1) ? $clog2(M_COUNT) : 1;

  typedef enum logic [1:0] {IDLE, PASS, DROP} state_t;

  state_t               state_reg, state_next;
  logic [M_COUNT-1:0]   route_mask_reg, route_mask_next;
  logic [PTR_W-1:0]     rr_ptr_reg, rr_ptr_next;
  logic                 pkt_drop_reg, pkt_drop_next;

  logic [M_COUNT-1:0]    tvalid_reg;
  logic [M_COUNT-1:0]    tlast_reg;
  logic [DATA_WIDTH-1:0] tdata_reg [M_COUNT];

  logic [PTR_W-1:0]   grant_idx;
  logic               grant_found;
  logic [M_COUNT-1:0] tgt;
  logic [M_COUNT-1:0] slot_free;
  logic               accept;

  // Round-robin search: first set bit of dest_mask strictly after rr_ptr, wrapping.
  always_comb begin
    logic [PTR_W:0] idx;
    grant_idx   = '0;
    grant_found = 1'b0;
    idx         = '0;
    for (int k = 1; k <= M_COUNT; k++) begin
      idx = {1'b0, rr_ptr_reg} + (PTR_W+1)'(k);
      if (idx >= (PTR_W+1)'(M_COUNT)) idx = idx - (PTR_W+1)'(M_COUNT);
      if (!grant_found && dest_mask[idx[PTR_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = idx[PTR_W-1:0];
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      route_mask_reg <= '0;
      rr_ptr_reg     <= PTR_W'(M_COUNT - 1);
      pkt_drop_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      route_mask_reg <= route_mask_next;
      rr_ptr_reg     <= rr_ptr_next;
      pkt_drop_reg   <= pkt_drop_next;
    end
  end

  // Output / routing decode
  always_comb begin
    tgt = '0;
    case (state_reg)
      IDLE: begin
        if (fork_enable)      tgt = dest_mask;
        else if (grant_found) tgt = M_COUNT'(1) << grant_idx;
      end
      PASS:    tgt = route_mask_reg;
      default: tgt = '0;
    endcase
    slot_free     = ~tvalid_reg | m_axis_tready;
    // A beat is committed to every target together or not at all.
    s_axis_tready = !rst && (&(~tgt | slot_free));
    accept        = s_axis_tvalid && s_axis_tready;
    busy          = (state_reg != IDLE);
    pkt_drop      = pkt_drop_reg;
  end

  // Next-state logic
  always_comb begin
    state_next      = state_reg;
    route_mask_next = route_mask_reg;
    rr_ptr_next     = rr_ptr_reg;
    pkt_drop_next   = 1'b0;
    if (accept) begin
      case (state_reg)
        IDLE: begin
          if (tgt == '0) begin
            pkt_drop_next = 1'b1;
            if (!s_axis_tlast) state_next = DROP;
          end else begin
            if (!s_axis_tlast) begin
              state_next      = PASS;
              route_mask_next = tgt;
            end
            if (!fork_enable) rr_ptr_next = grant_idx;
          end
        end
        default: begin
          if (s_axis_tlast) state_next = IDLE;
        end
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < M_COUNT; gi++) begin : g_slot
      // A reload wins over a drain, so a slot can turn over every cycle.
      always_ff @(posedge clk) begin
        if (rst) begin
          tvalid_reg[gi] <= 1'b0;
          tlast_reg[gi]  <= 1'b0;
          tdata_reg[gi]  <= '0;
        end else if (accept && tgt[gi]) begin
          tvalid_reg[gi] <= 1'b1;
          tlast_reg[gi]  <= s_axis_tlast;
          tdata_reg[gi]  <= s_axis_tdata;
        end else if (m_axis_tready[gi]) begin
          tvalid_reg[gi] <= 1'b0;
        end
      end

      assign m_axis_tdata[gi*DATA_WIDTH +: DATA_WIDTH] = tdata_reg[gi];
      assign m_axis_tlast[gi]  = tlast_reg[gi];
      assign m_axis_tvalid[gi] = tvalid_reg[gi];
    end
  endgenerate

endmodule

// File: tb/tb_axis_fork_router.sv
// Scoreboard bench for axis_fork_router: stimulus pushes per-port expectations,
// a negedge monitor pops and compares every output handshake.
module tb_axis_fork_router;

  localparam int M  = 4;
  localparam int DW = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic            fork_enable;
  logic [M-1:0]    dest_mask;
  logic            s_axis_tready;
  logic [DW-1:0]   s_axis_tdata;
  logic            s_axis_tlast;
  logic            s_axis_tvalid;
  logic [M-1:0]    m_axis_tready;
  logic [M*DW-1:0] m_axis_tdata;
  logic [M-1:0]    m_axis_tlast;
  logic [M-1:0]    m_axis_tvalid;
  logic            busy;
  logic            pkt_drop;

  axis_fork_router #(.M_COUNT(M), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .fork_enable(fork_enable), .dest_mask(dest_mask),
    .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
    .s_axis_tlast(s_axis_tlast), .s_axis_tvalid(s_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata),
    .m_axis_tlast(m_axis_tlast), .m_axis_tvalid(m_axis_tvalid),
    .busy(busy), .pkt_drop(pkt_drop)
  );

  always #5 clk = ~clk;

  typedef logic [DW:0] ent_t;   // {tlast, tdata}
  typedef ent_t q_t[$];
  q_t exp_q [M];

  int total    = 0;
  int bad      = 0;
  int drop_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Issue one beat, recording where it must appear; returns cycles spent stalled.
  task automatic send(input logic [DW-1:0] d, input logic l, input logic [M-1:0] exp_mask,
                      output int waited);
    for (int i = 0; i < M; i++)
      if (exp_mask[i]) exp_q[i].push_back({l, d});
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    waited = 0;
    forever begin
      @(negedge clk);
      if (s_axis_tready) break;
      waited++;
      if (waited > 200) begin
        total++;
        bad++;
        $display("FAIL send_timeout: beat %0h not accepted within 200 cycles", d);
        break;
      end
    end
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
  endtask

  // Monitor: handshakes seen at negedge complete on the following posedge.
  always @(negedge clk) begin
    if (!rst) begin
      if (pkt_drop) drop_cnt++;
      for (int i = 0; i < M; i++) begin
        if (m_axis_tvalid[i] && m_axis_tready[i]) begin
          if (exp_q[i].size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_beat port%0d: got data %0h, none expected",
                     i, m_axis_tdata[i*DW +: DW]);
          end else begin
            ent_t e;
            e = exp_q[i].pop_front();
            chk($sformatf("port%0d_data", i), m_axis_tdata[i*DW +: DW], e[DW-1:0]);
            chk($sformatf("port%0d_last", i), 64'(m_axis_tlast[i]), 64'(e[DW]));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int d0;
    int left;
    rst           = 1'b1;
    fork_enable   = 1'b0;
    dest_mask     = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = '1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_tvalid", 64'(m_axis_tvalid), 64'h0);
    chk("reset_tready", 64'(s_axis_tready), 64'h0);
    chk("reset_busy", 64'(busy), 64'h0);
    chk("reset_pkt_drop", 64'(pkt_drop), 64'h0);
    chk("reset_tlast", 64'(m_axis_tlast), 64'h0);
    chk("reset_tdata", 64'(|m_axis_tdata), 64'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Broadcast to ports 0,1,3
    fork_enable = 1'b1;
    dest_mask   = 4'b1011;
    send(64'h11, 1'b0, 4'b1011, w);
    chk("bc_wait_b1", 64'(w), 64'h0);
    chk("bc_busy", 64'(busy), 64'h1);
    send(64'h22, 1'b0, 4'b1011, w);
    chk("bc_wait_b2", 64'(w), 64'h0);
    send(64'h33, 1'b1, 4'b1011, w);
    chk("bc_wait_b3", 64'(w), 64'h0);
    cyc(2);
    chk("bc_idle_busy", 64'(busy), 64'h0);

    // Round-robin over mask 0110 starting from rr_ptr=3: 1,2,1,2
    fork_enable = 1'b0;
    dest_mask   = 4'b0110;
    send(64'hA0, 1'b1, 4'b0010, w);
    send(64'hA1, 1'b1, 4'b0100, w);
    send(64'hA2, 1'b1, 4'b0010, w);
    send(64'hA3, 1'b1, 4'b0100, w);
    cyc(2);

    // Stall: port 1 not ready for 5 cycles
    fork_enable   = 1'b1;
    dest_mask     = 4'b0011;
    m_axis_tready = 4'b1101;
    fork
      begin
        send(64'h51, 1'b0, 4'b0011, w);
        send(64'h52, 1'b0, 4'b0011, w);
        send(64'h53, 1'b1, 4'b0011, w);
      end
      begin
        repeat (5) @(negedge clk);
        chk("stall_tready", 64'(s_axis_tready), 64'h0);
        chk("stall_port0_idle", 64'(m_axis_tvalid[0]), 64'h0);
        chk("stall_port1_held", 64'(m_axis_tvalid[1]), 64'h1);
        @(posedge clk);
        #1;
        m_axis_tready = '1;
      end
    join
    cyc(2);

    // Drop: empty mask, 2-beat packet
    d0          = drop_cnt;
    fork_enable = 1'b0;
    dest_mask   = 4'b0000;
    send(64'h61, 1'b0, 4'b0000, w);
    chk("drop_wait_b1", 64'(w), 64'h0);
    chk("drop_busy", 64'(busy), 64'h1);
    send(64'h62, 1'b1, 4'b0000, w);
    chk("drop_wait_b2", 64'(w), 64'h0);
    cyc(2);
    chk("drop_pulses", 64'(drop_cnt - d0), 64'h1);
    dest_mask = 4'b0001;
    send(64'h71, 1'b1, 4'b0001, w);
    cyc(2);

    // Mask change mid-packet: rr_ptr=0, mask 1000 grants port 3
    dest_mask = 4'b1000;
    send(64'h81, 1'b0, 4'b1000, w);
    dest_mask   = 4'b0001;
    fork_enable = 1'b1;
    send(64'h82, 1'b0, 4'b1000, w);
    send(64'h83, 1'b1, 4'b1000, w);
    cyc(2);

    // Reset mid-packet with a full slot (rr_ptr=3 -> grant port 1, rr_ptr becomes 1)
    fork_enable   = 1'b0;
    dest_mask     = 4'b0110;
    m_axis_tready = '0;
    send(64'h91, 1'b0, 4'b0000, w);
    chk("rst_pre_busy", 64'(busy), 64'h1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_tready", 64'(s_axis_tready), 64'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_tvalid", 64'(m_axis_tvalid), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    @(posedge clk);
    #1;
    m_axis_tready = '1;
    // rr_ptr back at 3, so the lowest set bit (port 1) wins rather than port 2
    send(64'hA5, 1'b1, 4'b0010, w);

    // Drain: every expected beat must have been seen
    left = 0;
    for (int c = 0; c < 50; c++) begin
      left = 0;
      for (int i = 0; i < M; i++) left += exp_q[i].size();
      if (left == 0) break;
      cyc(1);
    end
    for (int i = 0; i < M; i++)
      chk($sformatf("port%0d_pending", i), 64'(exp_q[i].size()), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
